driver_dispensador: RTL and testbench

Output-side driver for the dispenser controller. It consumes the registered command pair AD (dispense) and A (alarm) from the dispenser FSM and turns them into physical actuation:
- a fixed-length pump pulse per presence, followed by a mandatory pause;
- a latched alarm with a blinking LED and a steady buzzer;
- a saturating count of completed doses.

It sits between the dispenser FSM and the board pins.

---
 rtl/driver_dispensador_pkg.sv | 34 +++
 rtl/driver_dispensador_temporizador_carga.sv | 36 +++
 rtl/driver_dispensador.sv | 155 +++++++++++++++
 tb/tb_driver_dispensador.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_dispensador_pkg.sv
// Shared definitions for the dispenser output driver: state encodings, the upstream
// dispenser FSM encodings and the default board timing constants.
package driver_dispensador_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    BOMBEANDO = 2'b01,
    PAUSA     = 2'b10,
    ALARME    = 2'b11
  } drv_estado_e;

  // Encodings of the upstream dispenser FSM that produces AD/A. The prefix keeps
  // its alarm literal distinct from the driver's own ALARME state.
  typedef enum logic [1:0] {
    FSM_ESPERAR = 2'b00,
    FSM_ALARME  = 2'b01,
    FSM_ACIONAR = 2'b10
  } fsm_estado_e;

  localparam int T_BOMBA_PADRAO = 50_000_000;
  localparam int T_PAUSA_PADRAO = 25_000_000;
  localparam int T_PISCA_PADRAO = 12_500_000;
  localparam int CW_PADRAO      = 26;

  localparam logic [7:0] DOSES_MAX = 8'd255;

  function automatic logic [7:0] incr_sat(input logic [7:0] v);
    if (v == DOSES_MAX) begin
      return v;
    end
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/driver_dispensador_temporizador_carga.sv
// Loadable down-counter with zero flag; one instance is time-shared by the pump,
// pause and blink phases of the driver.
module temporizador_carga #(
  parameter int CW = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic          habilita,
  input  logic [CW-1:0] valor,
  output logic          zero
);

  logic [CW-1:0] contagem_q;
  logic [CW-1:0] contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (carga) begin
      contagem_d = valor;
    end else if (habilita && (contagem_q != '0)) begin
      contagem_d = contagem_q - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign zero = (contagem_q == '0);

endmodule

// File: rtl/driver_dispensador.sv
// Output driver for the dispenser: fixed-length pump pulse with post-dose lockout,
// latched blinking alarm, and a saturating dose counter.
module driver_dispensador
  import driver_dispensador_pkg::*;
#(
  parameter int T_BOMBA = T_BOMBA_PADRAO,
  parameter int T_PAUSA = T_PAUSA_PADRAO,
  parameter int T_PISCA = T_PISCA_PADRAO,
  parameter int CW      = CW_PADRAO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AD,
  input  logic       A,
  output logic       BOMBA,
  output logic       LED_ALARME,
  output logic       SOM,
  output logic       OCUPADO,
  output logic [7:0] DOSES
);

  localparam logic [CW-1:0] CARGA_BOMBA = CW'(T_BOMBA - 1);
  localparam logic [CW-1:0] CARGA_PAUSA = CW'(T_PAUSA - 1);
  localparam logic [CW-1:0] CARGA_PISCA = CW'(T_PISCA - 1);

  drv_estado_e estado_q, estado_d;
  logic        armado_q, armado_d;
  logic        bomba_q, bomba_d;
  logic        led_q, led_d;
  logic        som_q, som_d;
  logic        ocupado_q, ocupado_d;
  logic [7:0]  doses_q, doses_d;

  logic          tmr_carga;
  logic          tmr_habilita;
  logic [CW-1:0] tmr_valor;
  logic          tmr_zero;

  temporizador_carga #(
    .CW(CW)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .carga    (tmr_carga),
    .habilita (tmr_habilita),
    .valor    (tmr_valor),
    .zero     (tmr_zero)
  );

  // Next state, timer control and dose counting. A is checked first everywhere so
  // an alarm always wins over a pending or running dose.
  always_comb begin
    estado_d     = estado_q;
    armado_d     = armado_q | ~AD;
    doses_d      = doses_q;
    tmr_carga    = 1'b0;
    tmr_habilita = 1'b0;
    tmr_valor    = '0;

    case (estado_q)
      OCIOSO: begin
        if (A) begin
          estado_d  = ALARME;
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PISCA;
        end else if (AD && armado_q) begin
          estado_d  = BOMBEANDO;
          tmr_carga = 1'b1;
          tmr_valor = CARGA_BOMBA;
          armado_d  = 1'b0;
        end
      end
      BOMBEANDO: begin
        if (A) begin
          estado_d  = ALARME;
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PISCA;
        end else if (tmr_zero) begin
          estado_d  = PAUSA;
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PAUSA;
          doses_d   = incr_sat(doses_q);
        end else begin
          tmr_habilita = 1'b1;
        end
      end
      PAUSA: begin
        if (A) begin
          estado_d  = ALARME;
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PISCA;
        end else if (tmr_zero) begin
          estado_d = OCIOSO;
        end else begin
          tmr_habilita = 1'b1;
        end
      end
      ALARME: begin
        if (tmr_zero) begin
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PISCA;
        end else begin
          tmr_habilita = 1'b1;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as it.
  always_comb begin
    bomba_d   = (estado_d == BOMBEANDO);
    som_d     = (estado_d == ALARME);
    ocupado_d = (estado_d == BOMBEANDO) || (estado_d == PAUSA);
    led_d     = 1'b0;
    if (estado_d == ALARME) begin
      if (estado_q != ALARME) begin
        led_d = 1'b1;
      end else if (tmr_zero) begin
        led_d = ~led_q;
      end else begin
        led_d = led_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      armado_q  <= 1'b0;
      bomba_q   <= 1'b0;
      led_q     <= 1'b0;
      som_q     <= 1'b0;
      ocupado_q <= 1'b0;
      doses_q   <= 8'd0;
    end else begin
      estado_q  <= estado_d;
      armado_q  <= armado_d;
      bomba_q   <= bomba_d;
      led_q     <= led_d;
      som_q     <= som_d;
      ocupado_q <= ocupado_d;
      doses_q   <= doses_d;
    end
  end

  assign BOMBA      = bomba_q;
  assign LED_ALARME = led_q;
  assign SOM        = som_q;
  assign OCUPADO    = ocupado_q;
  assign DOSES      = doses_q;

endmodule

// File: tb/tb_driver_dispensador.sv
// Self-checking bench for driver_dispensador against a cycle-count reference model.
module tb_driver_dispensador;

  localparam int T_BOMBA = 4;
  localparam int T_PAUSA = 3;
  localparam int T_PISCA = 2;
  localparam int CW      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ad = 1'b0;
  logic       a = 1'b0;
  logic       BOMBA, LED_ALARME, SOM, OCUPADO;
  logic [7:0] DOSES;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining pump/pause cycles, cycles since alarm entry.
  bit m_alarm;
  int m_age;
  int m_pump;
  int m_pause;
  int m_doses;
  bit m_armed;

  driver_dispensador #(
    .T_BOMBA(T_BOMBA),
    .T_PAUSA(T_PAUSA),
    .T_PISCA(T_PISCA),
    .CW     (CW)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .AD         (ad),
    .A          (a),
    .BOMBA      (BOMBA),
    .LED_ALARME (LED_ALARME),
    .SOM        (SOM),
    .OCUPADO    (OCUPADO),
    .DOSES      (DOSES)
  );

  always #5 clk = ~clk;

  wire [11:0] dut_out = {BOMBA, LED_ALARME, SOM, OCUPADO, DOSES};

  function automatic logic [11:0] exp_out();
    logic e_bomba, e_led, e_som, e_ocup;
    e_bomba = !m_alarm && (m_pump > 0);
    e_ocup  = !m_alarm && ((m_pump > 0) || (m_pause > 0));
    e_som   = m_alarm;
    e_led   = m_alarm && (((m_age / T_PISCA) % 2) == 0);
    return {e_bomba, e_led, e_som, e_ocup, 8'(m_doses)};
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_age = 0; m_pump = 0; m_pause = 0; m_doses = 0; m_armed = 0;
  endtask

  task automatic model_step();
    if (m_alarm) begin
      m_age++;
    end else if (a) begin
      m_alarm = 1; m_age = 0; m_pump = 0; m_pause = 0;
    end else if (m_pump > 0) begin
      m_pump--;
      if (m_pump == 0) begin
        if (m_doses < 255) m_doses++;
        m_pause = T_PAUSA;
      end
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (ad && m_armed) begin
      m_pump  = T_BOMBA;
      m_armed = 0;
    end
    if (!ad) m_armed = 1;
  endtask

  // One clock edge: model samples the same inputs as the DUT, then settle to negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a = 0; ad = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dut_out !== 12'h000) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", dut_out, 12'h000);
    end
    rst_n = 1'b1;
    $display("[TB] reset: outputs %h", dut_out);
  endtask

  task automatic test_single_dose();
    int n_bomba = 0;
    int n_ocup = 0;
    ad = 0; tick(); tick();
    ad = 1; tick();
    ad = 0;
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        $display("FAIL single_dose cycle %0d: got %h expected %h", i, dut_out, exp_out());
      end
      n_bomba += int'(BOMBA);
      n_ocup  += int'(OCUPADO);
      tick();
    end
    tests++;
    if (n_bomba != T_BOMBA || n_ocup != T_BOMBA + T_PAUSA || DOSES !== 8'd1) begin
      fails++;
      $display("FAIL single_dose_len: bomba %0d ocupado %0d doses %0d expected %0d %0d 1",
               n_bomba, n_ocup, DOSES, T_BOMBA, T_BOMBA + T_PAUSA);
    end
    $display("[TB] single dose: bomba cycles %0d ocupado cycles %0d doses %0d", n_bomba, n_ocup, DOSES);
  endtask

  task automatic test_held_ad();
    do_reset();
    ad = 0; tick();
    ad = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        $display("FAIL held_ad cycle %0d: got %h expected %h", i, dut_out, exp_out());
      end
    end
    tests++;
    if (DOSES !== 8'd1) begin
      fails++;
      $display("FAIL held_ad_one_dose: got %0d expected 1", DOSES);
    end
    ad = 0; tick();
    ad = 1; tick();
    ad = 0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        $display("FAIL held_ad_second cycle %0d: got %h expected %h", i, dut_out, exp_out());
      end
      tick();
    end
    tests++;
    if (DOSES !== 8'd2) begin
      fails++;
      $display("FAIL held_ad_two_doses: got %0d expected 2", DOSES);
    end
    $display("[TB] held AD: doses %0d", DOSES);
  endtask

  task automatic test_alarm_mid_dose();
    do_reset();
    ad = 0; tick();
    ad = 1; tick();
    ad = 0; tick();
    a = 1; tick();
    tests++;
    if (BOMBA !== 1'b0 || SOM !== 1'b1 || LED_ALARME !== 1'b1 || DOSES !== 8'd0) begin
      fails++;
      $display("FAIL alarm_entry: got bomba %b som %b led %b doses %0d expected 0 1 1 0",
               BOMBA, SOM, LED_ALARME, DOSES);
    end
    a = 0;
    for (int i = 0; i < 12; i++) begin
      ad = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        $display("FAIL alarm_blink cycle %0d: got %h expected %h", i, dut_out, exp_out());
      end
    end
    $display("[TB] alarm mid-dose: led %b som %b doses %0d", LED_ALARME, SOM, DOSES);
  endtask

  task automatic test_simultaneous();
    int n_bomba = 0;
    do_reset();
    ad = 0; tick();
    a = 1; ad = 1; tick();
    tests++;
    if (SOM !== 1'b1 || BOMBA !== 1'b0) begin
      fails++;
      $display("FAIL simultaneous_entry: got som %b bomba %b expected 1 0", SOM, BOMBA);
    end
    a = 0;
    for (int i = 0; i < 8; i++) begin
      ad = ~ad;
      tick();
      n_bomba += int'(BOMBA);
    end
    tests++;
    if (n_bomba != 0) begin
      fails++;
      $display("FAIL simultaneous_no_pump: got %0d pump cycles expected 0", n_bomba);
    end
    $display("[TB] simultaneous A/AD: som %b pump cycles %0d", SOM, n_bomba);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int d = 0; d < 260; d++) begin
      ad = 0; tick();
      ad = 1; tick();
      ad = 0;
      for (int i = 0; i < T_BOMBA + T_PAUSA; i++) tick();
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        $display("FAIL saturation dose %0d: got %h expected %h", d, dut_out, exp_out());
      end
    end
    tests++;
    if (DOSES !== 8'd255) begin
      fails++;
      $display("FAIL saturation_final: got %0d expected 255", DOSES);
    end
    $display("[TB] saturation: doses %0d after 260 doses", DOSES);
  endtask

  task automatic test_random();
    int n_err = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      a  = ($urandom_range(0, 199) == 0);
      ad = ($urandom_range(0, 2) != 0);
      tick();
      tests++;
      if (dut_out !== exp_out()) begin
        fails++;
        n_err++;
        $display("FAIL random cycle %0d: got %h expected %h", i, dut_out, exp_out());
      end
    end
    a = 0;
    $display("[TB] random: 600 cycles, %0d errors", n_err);
  endtask

  task automatic test_async_reset();
    int n_bomba = 0;
    do_reset();
    ad = 0; tick();
    ad = 1; tick();
    ad = 0;
    for (int i = 0; i < T_BOMBA + T_PAUSA; i++) tick();
    ad = 0; tick();
    ad = 1; tick();
    tick();
    tests++;
    if (BOMBA !== 1'b1 || DOSES !== 8'd1) begin
      fails++;
      $display("FAIL async_pre: got bomba %b doses %0d expected 1 1", BOMBA, DOSES);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (BOMBA !== 1'b0 || OCUPADO !== 1'b0 || DOSES !== 8'd0) begin
      fails++;
      $display("FAIL async_clear: got bomba %b ocupado %b doses %0d expected 0 0 0",
               BOMBA, OCUPADO, DOSES);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_bomba += int'(BOMBA);
    end
    tests++;
    if (n_bomba != 0) begin
      fails++;
      $display("FAIL async_no_rearm: got %0d pump cycles expected 0", n_bomba);
    end
    ad = 0; tick();
    ad = 1; tick();
    tests++;
    if (BOMBA !== 1'b1 || dut_out !== exp_out()) begin
      fails++;
      $display("FAIL async_rearm: got %h expected %h", dut_out, exp_out());
    end
    ad = 0;
    $display("[TB] async reset: cleared, pump after rearm %b", BOMBA);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_dose();
    test_held_ad();
    test_alarm_mid_dose();
    test_simultaneous();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
